// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
package mips_arb_pkg;
  localparam int ARB_AW = 32;
  localparam int ARB_DW = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
  typedef enum logic       {OWN_IF, OWN_DM}                arb_owner_t;
endpackage

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// BUSY-cycle counter for the arbiter. expire is high while the count sits
// on TIMEOUT_CYC-1, i.e. during the last cycle a mem_ack is still accepted.
module arb_timeout_ctr #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic resetN,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)               cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !expire)    cnt <= cnt + 1'b1;
  end

  assign expire = (cnt == LAST);
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between fetch (if_*) and load/store (dm_*).
// Default arbitration gives dm fixed priority; define ARB_ROUND_ROBIN_EN for
// alternating priority on simultaneous requests.
module mem_port_arbiter
  import mips_arb_pkg::*;
#(
  parameter int AW          = ARB_AW,
  parameter int DW          = ARB_DW,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          rsp_err,
  output logic          busy
);
  arb_state_t state;
  arb_owner_t owner;
  logic       win_dm;
  logic       tmo_expire;

`ifdef ARB_ROUND_ROBIN_EN
  // Tracks who was served last; on a tie the other requester wins.
  arb_owner_t last_own;

  assign win_dm = dm_req && (!if_req || last_own == OWN_IF);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN)
      last_own <= OWN_IF;
    else if (state == ARB_IDLE && (if_req || dm_req))
      last_own <= win_dm ? OWN_DM : OWN_IF;
  end
`else
  assign win_dm = dm_req;
`endif

  // Counter sits at zero throughout IDLE so it starts clean on BUSY entry.
  arb_timeout_ctr #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .resetN (resetN),
    .clr    (state == ARB_IDLE),
    .en     (state == ARB_BUSY),
    .expire (tmo_expire)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= ARB_IDLE;
      owner     <= OWN_IF;
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      dm_gnt    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      case (state)
        ARB_IDLE: if (if_req || dm_req) begin
          state     <= ARB_BUSY;
          busy      <= 1'b1;
          mem_req   <= 1'b1;
          owner     <= win_dm ? OWN_DM : OWN_IF;
          mem_we    <= win_dm && dm_we;
          mem_addr  <= win_dm ? dm_addr : if_addr;
          mem_wdata <= win_dm ? dm_wdata : '0;
          if_gnt    <= !win_dm;
          dm_gnt    <= win_dm;
        end
        // An ack on the expiring cycle wins over the abort.
        ARB_BUSY: if (mem_ack || tmo_expire) begin
          state   <= ARB_RESP;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          rsp_err <= !mem_ack;
          if (owner == OWN_DM) begin
            dm_rvalid <= 1'b1;
            dm_rdata  <= (mem_ack && !mem_we) ? mem_rdata : '0;
          end else begin
            if_rvalid <= 1'b1;
            if_rdata  <= mem_ack ? mem_rdata : '0;
          end
        end
        ARB_RESP: begin
          state   <= ARB_IDLE;
          busy    <= 1'b0;
          rsp_err <= 1'b0;
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (default fixed-priority build).
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        resetN;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic        if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we, rsp_err, busy;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  int          total = 0;
  int          bad   = 0;
  int          early;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .resetN(resetN),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetN = 1'b0; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    step(); step();
    resetN = 1'b1;
    step();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gnts", {if_gnt, dm_gnt, if_rvalid, dm_rvalid, rsp_err, mem_we}, 0);

    // fetch read, ack two edges after acceptance
    if_req = 1; if_addr = 32'h0000_0008;
    step();
    chk("f_if_gnt", if_gnt, 1);
    chk("f_mem_req", mem_req, 1);
    chk("f_mem_addr", mem_addr, 32'h8);
    chk("f_mem_we", mem_we, 0);
    chk("f_busy", busy, 1);
    if_req = 0;
    step();
    chk("f_gnt_pulse", if_gnt, 0);
    chk("f_req_held", mem_req, 1);
    mem_ack = 1; mem_rdata = 32'h8C01_0004;
    step();
    mem_ack = 0;
    chk("f_rvalid", if_rvalid, 1);
    chk("f_rdata", if_rdata, 32'h8C01_0004);
    chk("f_err", rsp_err, 0);
    chk("f_req_drop", mem_req, 0);
    step();
    chk("f_rvalid_pulse", if_rvalid, 0);
    chk("f_idle", busy, 0);

    // contention: dm write wins, fetch waits
    if_req = 1; if_addr = 32'h0000_000C;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    step();
    chk("c_dm_gnt", dm_gnt, 1);
    chk("c_if_gnt_lose", if_gnt, 0);
    chk("c_mem_we", mem_we, 1);
    chk("c_mem_addr", mem_addr, 32'h100);
    chk("c_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    dm_req = 0; dm_we = 0;
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    step();
    mem_ack = 0;
    chk("w_dm_rvalid", dm_rvalid, 1);
    chk("w_dm_rdata", dm_rdata, 0);
    chk("w_mem_we_drop", mem_we, 0);
    chk("c_if_still_wait", {if_gnt, if_rvalid}, 0);
    step();
    chk("w_rvalid_pulse", dm_rvalid, 0);
    chk("w_idle", busy, 0);
    step();
    chk("c_if_gnt", if_gnt, 1);
    chk("c_if_addr", mem_addr, 32'hC);
    if_req = 0;
    mem_ack = 1; mem_rdata = 32'h1234_5678;
    step();
    mem_ack = 0;
    chk("c_if_rvalid", if_rvalid, 1);
    chk("c_if_rdata", if_rdata, 32'h1234_5678);
    chk("c_dm_rdata_hold", dm_rdata, 0);
    step();

    // ack on the 16th BUSY cycle still succeeds
    dm_req = 1; dm_we = 0; dm_addr = 32'h300;
    step();
    chk("b_dm_gnt", dm_gnt, 1);
    dm_req = 0;
    early = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (dm_rvalid || !mem_req) early++;
    end
    chk("b_no_early", early, 0);
    mem_ack = 1; mem_rdata = 32'hA5A5_0001;
    step();
    mem_ack = 0;
    chk("b_rvalid", dm_rvalid, 1);
    chk("b_err", rsp_err, 0);
    chk("b_rdata", dm_rdata, 32'hA5A5_0001);
    step();

    // no ack at all: abort after 16 BUSY cycles
    dm_req = 1; dm_addr = 32'h200;
    step();
    chk("t_dm_gnt", dm_gnt, 1);
    dm_req = 0;
    early = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (dm_rvalid || !mem_req) early++;
    end
    chk("t_no_early", early, 0);
    chk("t_busy", busy, 1);
    step();
    chk("t_rvalid", dm_rvalid, 1);
    chk("t_err", rsp_err, 1);
    chk("t_rdata_zero", dm_rdata, 0);
    chk("t_req_drop", mem_req, 0);
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    step();
    chk("t_late_ack", {dm_rvalid, if_rvalid, rsp_err, busy}, 0);
    step();
    mem_ack = 0;
    chk("t_late_ack2", {dm_rvalid, if_rvalid, mem_req, busy}, 0);
    chk("t_rdata_keep", dm_rdata, 0);

    // reset mid-BUSY drops the transaction
    dm_req = 1; dm_addr = 32'h40;
    step();
    dm_req = 0;
    step();
    chk("r_busy_before", busy, 1);
    resetN = 0;
    #1;
    chk("r_outs", {mem_req, mem_we, busy, rsp_err, if_gnt, dm_gnt, if_rvalid, dm_rvalid}, 0);
    chk("r_mem_addr", mem_addr, 0);
    chk("r_if_rdata", if_rdata, 0);
    step();
    resetN = 1;
    mem_ack = 1; mem_rdata = 32'h0BAD_0BAD;
    step();
    mem_ack = 0;
    early = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (dm_rvalid || if_rvalid || busy || mem_req) early++;
    end
    chk("r_no_rvalid", early, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
